// File: rtl/hack_cpu_pkg.sv
// -----------------------------------------------------------------------------
// hack_cpu_pkg
// Shared definitions for the Hack CPU core: word/address widths, instruction
// bit positions, the decoded C-instruction view and the jump-condition helper.
// No ports (package).
// -----------------------------------------------------------------------------
package hack_cpu_pkg;

   localparam int WIDTH   = 16;
   localparam int AW      = 15;

   localparam int BIT_CI  = 15;
   localparam int BIT_A   = 12;
   localparam int COMP_HI = 11;
   localparam int COMP_LO = 6;
   localparam int DEST_A  = 5;
   localparam int DEST_D  = 4;
   localparam int DEST_M  = 3;
   localparam int J_LT    = 2;
   localparam int J_EQ    = 1;
   localparam int J_GT    = 0;

   // dest = {A, D, M}, jump = {lt, eq, gt}
   typedef struct packed {
      logic       is_c;
      logic       a;
      logic [5:0] comp;
      logic [2:0] dest;
      logic [2:0] jump;
   } decode_t;

   function automatic decode_t decode(input logic [WIDTH-1:0] instr);
      decode_t d;
      d.is_c = instr[BIT_CI];
      d.a    = instr[BIT_A];
      d.comp = instr[COMP_HI:COMP_LO];
      d.dest = {instr[DEST_A], instr[DEST_D], instr[DEST_M]};
      d.jump = {instr[J_LT], instr[J_EQ], instr[J_GT]};
      return d;
   endfunction

   // gt means strictly positive: neither negative nor zero
   function automatic logic jump_take(input logic [2:0] jump,
                                      input logic       zr,
                                      input logic       ng);
      return (jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~ng & ~zr);
   endfunction

endpackage

// File: rtl/hack_cpu_alu.sv
// -----------------------------------------------------------------------------
// hack_cpu_alu
// Hack ALU. Each operand can be zeroed then inverted, the pair is added or
// ANDed, and the result can be inverted.
// Ports:
//   x, y            in   WIDTH  operands
//   zx,nx,zy,ny,f,no in  1      control bits
//   out             out  WIDTH  result
//   zr              out  1      out == 0
//   ng              out  1      out is negative (sign bit)
// -----------------------------------------------------------------------------
module hack_cpu_alu
   import hack_cpu_pkg::*;
(
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             zx,
   input  logic             nx,
   input  logic             zy,
   input  logic             ny,
   input  logic             f,
   input  logic             no,
   output logic [WIDTH-1:0] out,
   output logic             zr,
   output logic             ng
);

   logic [WIDTH-1:0] x_z_s;
   logic [WIDTH-1:0] x_n_s;
   logic [WIDTH-1:0] y_z_s;
   logic [WIDTH-1:0] y_n_s;
   logic [WIDTH-1:0] f_s;

   assign x_z_s = zx ? {WIDTH{1'b0}} : x;
   assign x_n_s = nx ? ~x_z_s : x_z_s;
   assign y_z_s = zy ? {WIDTH{1'b0}} : y;
   assign y_n_s = ny ? ~y_z_s : y_z_s;
   assign f_s   = f ? (x_n_s + y_n_s) : (x_n_s & y_n_s);
   assign out   = no ? ~f_s : f_s;
   assign zr    = (out == {WIDTH{1'b0}});
   assign ng    = out[WIDTH-1];

endmodule

// File: rtl/hack_cpu.sv
// -----------------------------------------------------------------------------
// hack_cpu
// Hack CPU core. Holds A, D and PC, decodes one instruction per clock, drives
// the ALU and the RAM interface, and selects the next PC from jump conditions.
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   synchronous active-high reset
//   instruction  in   16  instruction at pc
//   in_m         in   16  RAM read data at address_m
//   out_m        out  16  ALU result / RAM write data
//   write_m      out  1   RAM write enable
//   address_m    out  15  RAM address (A[14:0])
//   pc           out  15  instruction ROM address
// -----------------------------------------------------------------------------
module hack_cpu
   import hack_cpu_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] instruction,
   input  logic [WIDTH-1:0] in_m,
   output logic [WIDTH-1:0] out_m,
   output logic             write_m,
   output logic [AW-1:0]    address_m,
   output logic [AW-1:0]    pc
);

   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] d_r;
   logic [AW-1:0]    pc_r;

   decode_t          dec_s;
   logic [WIDTH-1:0] alu_y_s;
   logic [WIDTH-1:0] alu_out_s;
   logic             alu_zr_s;
   logic             alu_ng_s;
   logic             take_s;

   assign dec_s   = decode(instruction);
   assign alu_y_s = dec_s.a ? in_m : a_r;

   hack_cpu_alu u_alu (
      .x   (d_r),
      .y   (alu_y_s),
      .zx  (dec_s.comp[5]),
      .nx  (dec_s.comp[4]),
      .zy  (dec_s.comp[3]),
      .ny  (dec_s.comp[2]),
      .f   (dec_s.comp[1]),
      .no  (dec_s.comp[0]),
      .out (alu_out_s),
      .zr  (alu_zr_s),
      .ng  (alu_ng_s)
   );

   // The ALU flags are meaningless for an A-instruction, so gate them there
   assign take_s    = dec_s.is_c & jump_take(dec_s.jump, alu_zr_s, alu_ng_s);

   assign out_m     = alu_out_s;
   assign write_m   = ~reset & dec_s.is_c & dec_s.dest[0];
   assign address_m = a_r[AW-1:0];
   assign pc        = pc_r;

   // A, D and PC update; the jump target is the A value before this edge
   always_ff @(posedge clk) begin
      if (reset) begin
         a_r  <= {WIDTH{1'b0}};
         d_r  <= {WIDTH{1'b0}};
         pc_r <= {AW{1'b0}};
      end else begin
         if (!dec_s.is_c) begin
            a_r <= instruction;
         end else if (dec_s.dest[2]) begin
            a_r <= alu_out_s;
         end else begin
            a_r <= a_r;
         end

         if (dec_s.is_c && dec_s.dest[1]) begin
            d_r <= alu_out_s;
         end else begin
            d_r <= d_r;
         end

         // PC + 1 wraps from 0x7FFF to 0x0000 through natural overflow
         if (take_s) begin
            pc_r <= a_r[AW-1:0];
         end else begin
            pc_r <= pc_r + {{(AW-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule
